// File: rtl/reward_sched_if.sv
// Transmit-side packet bus of reward_sched: packet fields and valid/ready handshake.
interface reward_sched_if #(
   parameter int WORD_WIDTH = 16
);
   logic                  tx_valid;
   logic                  tx_ready;
   logic [2:0]            rPacketType;
   logic [WORD_WIDTH-1:0] rSourceID;
   logic [WORD_WIDTH-1:0] rEnergyLeft;
   logic [WORD_WIDTH-1:0] rQValue;
   logic [WORD_WIDTH-1:0] rSourceHops;
   logic [WORD_WIDTH-1:0] rDestinationID;
   logic [WORD_WIDTH-1:0] rChosenCH;
   logic [WORD_WIDTH-1:0] rHopsFromCH;
   logic [WORD_WIDTH-1:0] rTimeslot;

   modport master (
      output tx_valid, rPacketType, rSourceID, rEnergyLeft, rQValue, rSourceHops,
             rDestinationID, rChosenCH, rHopsFromCH, rTimeslot,
      input  tx_ready
   );

   modport slave (
      input  tx_valid, rPacketType, rSourceID, rEnergyLeft, rQValue, rSourceHops,
             rDestinationID, rChosenCH, rHopsFromCH, rTimeslot,
      output tx_ready
   );
endinterface

// File: rtl/reward_sched.sv
// EER-RL packet packer: picks HB/INV/MR/CHT/Data/SOS jobs, runs MR/CHT timeouts and
// sweeps the neighbor table as cluster head, emitting each packet over valid/ready.
module reward_sched #(
   parameter int                    WORD_WIDTH    = 16,
   parameter int                    MAX_NEIGHBORS = 32,
   parameter int                    MAX_CH_HOPS   = 4,
   parameter int                    MR_TIMEOUT    = 15,
   parameter int                    CHT_TIMEOUT   = 15,
   parameter logic [WORD_WIDTH-1:0] BCAST_ID      = {WORD_WIDTH{1'b1}},
   localparam int                   IDX_W         = $clog2(MAX_NEIGHBORS)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [2:0]            fPacketType,
   input  logic                  iAmDestination,
   input  logic                  iHaveData,
   input  logic                  low_E,
   input  logic                  role,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] myQValue,
   input  logic [WORD_WIDTH-1:0] hopsFromSink,
   input  logic [WORD_WIDTH-1:0] chosenCH,
   input  logic [WORD_WIDTH-1:0] hopsFromCH,
   input  logic [WORD_WIDTH-1:0] chosenHop,
   input  logic [IDX_W:0]        neighborCount,
   input  logic [WORD_WIDTH-1:0] mNodeID,
   output logic [IDX_W-1:0]      nTableIndex,
   output logic                  busy,
   output logic                  reward_done,
   reward_sched_if.master        tx
);

   localparam logic [2:0] T_HB = 3'd0, T_CHE = 3'd1, T_INV = 3'd2, T_MR = 3'd3;
   localparam logic [2:0] T_CHT = 3'd4, T_DATA = 3'd5, T_SOS = 3'd6, T_NONE = 3'd7;
   localparam int TMAX = (MR_TIMEOUT > CHT_TIMEOUT) ? MR_TIMEOUT : CHT_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {IDLE, EMIT, CHT_RD, CHT_EMIT, DONE} state_t;

   state_t                state, nxt;
   logic [IDX_W-1:0]      idx;
   logic [TW-1:0]         mr_cnt, cht_cnt;
   logic                  pend_mr, pend_cht, hb_lock, own_inv_q;
   logic                  ld, set_hb, arm_mr, own_inv, take_mr, take_cht, last;
   logic [2:0]            ld_type;
   logic [WORD_WIDTH-1:0] ld_dest, ld_hops, data_dest;

   assign data_dest   = (hopsFromSink == WORD_WIDTH'(1)) ? '0 : chosenHop;
   assign last        = ({1'b0, idx} == (neighborCount - (IDX_W+1)'(1)));
   assign nTableIndex = idx;
   assign busy        = (state != IDLE);
   assign reward_done = (state == DONE);

   always_ff @(posedge clk) begin
      if (nrst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt      = state;
      ld       = 1'b0;
      ld_type  = T_NONE;
      ld_dest  = BCAST_ID;
      ld_hops  = hopsFromCH;
      set_hb   = 1'b0;
      arm_mr   = 1'b0;
      own_inv  = 1'b0;
      take_mr  = 1'b0;
      take_cht = 1'b0;
      case (state)
         IDLE: begin
            if (pend_cht && role) begin
               take_cht = 1'b1;
               nxt      = (neighborCount == '0) ? DONE : CHT_RD;
            end else if (pend_mr && !role) begin
               take_mr = 1'b1;
               ld      = 1'b1;
               ld_type = T_MR;
               ld_dest = chosenCH;
               nxt     = EMIT;
            end else if (en) begin
               nxt = DONE;
               case (fPacketType)
                  T_HB: if (!hb_lock) begin
                     ld = 1'b1; ld_type = T_HB; set_hb = 1'b1; nxt = EMIT;
                  end
                  T_CHE: if (role) begin
                     ld = 1'b1; ld_type = T_INV; ld_hops = '0; own_inv = 1'b1; nxt = EMIT;
                  end
                  T_INV: if (!role) begin
                     // MR timer arming does not depend on whether the INV is rippled
                     arm_mr = (mr_cnt == '0);
                     if (hopsFromCH < WORD_WIDTH'(MAX_CH_HOPS)) begin
                        ld = 1'b1; ld_type = T_INV; ld_hops = hopsFromCH + WORD_WIDTH'(1); nxt = EMIT;
                     end
                  end
                  T_DATA, T_SOS: if (iAmDestination) begin
                     ld      = 1'b1;
                     ld_type = ((fPacketType == T_SOS) || low_E) ? T_SOS : T_DATA;
                     ld_dest = data_dest;
                     nxt     = EMIT;
                  end
                  default: ;
               endcase
            end else if (iHaveData) begin
               ld = 1'b1; ld_type = T_DATA; ld_dest = data_dest; nxt = EMIT;
            end
         end
         EMIT:     if (tx.tx_ready) nxt = DONE;
         CHT_RD:   nxt = CHT_EMIT;
         CHT_EMIT: if (tx.tx_ready) nxt = last ? DONE : CHT_RD;
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         tx.tx_valid       <= 1'b0;
         tx.rPacketType    <= T_NONE;
         tx.rDestinationID <= BCAST_ID;
         tx.rSourceID      <= '0;
         tx.rEnergyLeft    <= '0;
         tx.rQValue        <= '0;
         tx.rSourceHops    <= '0;
         tx.rChosenCH      <= '0;
         tx.rHopsFromCH    <= '0;
         tx.rTimeslot      <= '0;
         idx               <= '0;
         mr_cnt            <= '0;
         cht_cnt           <= '0;
         pend_mr           <= 1'b0;
         pend_cht          <= 1'b0;
         hb_lock           <= 1'b0;
         own_inv_q         <= 1'b0;
      end else begin
         // free-running timeouts; expiry leaves a sticky request for the next IDLE
         if (mr_cnt != '0) begin
            mr_cnt <= mr_cnt - TW'(1);
            if (mr_cnt == TW'(1)) pend_mr <= 1'b1;
         end
         if (cht_cnt != '0) begin
            cht_cnt <= cht_cnt - TW'(1);
            if (cht_cnt == TW'(1)) pend_cht <= 1'b1;
         end
         if (arm_mr) mr_cnt <= TW'(MR_TIMEOUT);
         if (state == EMIT && tx.tx_ready && own_inv_q) cht_cnt <= TW'(CHT_TIMEOUT);
         if (take_mr)  pend_mr  <= 1'b0;
         if (take_cht) begin
            pend_cht <= 1'b0;
            idx      <= '0;
         end
         if (role)  pend_mr  <= 1'b0;
         if (!role) pend_cht <= 1'b0;

         if (set_hb) hb_lock <= 1'b1;
         if (en && fPacketType == T_DATA) hb_lock <= 1'b0;

         if (ld) begin
            tx.tx_valid       <= 1'b1;
            tx.rPacketType    <= ld_type;
            tx.rDestinationID <= ld_dest;
            tx.rSourceID      <= myNodeID;
            tx.rEnergyLeft    <= myEnergy;
            tx.rQValue        <= myQValue;
            tx.rSourceHops    <= hopsFromSink;
            tx.rChosenCH      <= chosenCH;
            tx.rHopsFromCH    <= ld_hops;
            tx.rTimeslot      <= '0;
            own_inv_q         <= own_inv;
         end
         if (state == CHT_RD) begin
            tx.tx_valid       <= 1'b1;
            tx.rPacketType    <= T_CHT;
            tx.rDestinationID <= mNodeID;
            tx.rSourceID      <= myNodeID;
            tx.rEnergyLeft    <= myEnergy;
            tx.rQValue        <= myQValue;
            tx.rSourceHops    <= hopsFromSink;
            tx.rChosenCH      <= myNodeID;
            tx.rHopsFromCH    <= hopsFromCH;
            tx.rTimeslot      <= WORD_WIDTH'(idx) + WORD_WIDTH'(1);
            own_inv_q         <= 1'b0;
         end
         if ((state == EMIT || state == CHT_EMIT) && tx.tx_ready) tx.tx_valid <= 1'b0;
         if (state == CHT_EMIT && tx.tx_ready && !last) idx <= idx + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_reward_sched.sv
// Directed bench for reward_sched: a scoreboard queue holds the packets each step
// should produce; a negedge monitor pops and compares them at every handshake.
module tb_reward_sched;
   localparam logic [2:0] T_HB = 3'd0, T_CHE = 3'd1, T_INV = 3'd2, T_MR = 3'd3;
   localparam logic [2:0] T_CHT = 3'd4, T_DATA = 3'd5, T_SOS = 3'd6;

   logic        clk = 1'b0;
   logic        nrst, en, iAmDestination, iHaveData, low_E, role;
   logic [2:0]  fPacketType;
   logic [15:0] myNodeID, myEnergy, myQValue, hopsFromSink;
   logic [15:0] chosenCH, hopsFromCH, chosenHop, mNodeID;
   logic [5:0]  neighborCount;
   logic [4:0]  nTableIndex;
   logic        busy, reward_done;
   logic [15:0] tbl [32];

   int vectors = 0;
   int errors  = 0;
   int done_cnt = 0;
   int cyc = 0;

   typedef struct {
      logic [2:0]  t;
      logic [15:0] dest, chosen, slot, hops;
      bit          chk_hops;
   } pkt_t;
   pkt_t sb[$];
   pkt_t e;

   logic        stall_prev = 1'b0;
   logic [2:0]  s_type;
   logic [15:0] s_dest, s_slot, s_chosen;

   reward_sched_if #(.WORD_WIDTH(16)) tx ();

   reward_sched dut (
      .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
      .iAmDestination(iAmDestination), .iHaveData(iHaveData), .low_E(low_E), .role(role),
      .myNodeID(myNodeID), .myEnergy(myEnergy), .myQValue(myQValue), .hopsFromSink(hopsFromSink),
      .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .chosenHop(chosenHop),
      .neighborCount(neighborCount), .mNodeID(mNodeID), .nTableIndex(nTableIndex),
      .busy(busy), .reward_done(reward_done), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always_comb mNodeID = tbl[nTableIndex];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] t, input logic [15:0] dest, input logic [15:0] chosen,
                       input logic [15:0] slot, input logic [15:0] hops, input bit chk_hops);
      pkt_t p;
      p.t = t; p.dest = dest; p.chosen = chosen; p.slot = slot; p.hops = hops; p.chk_hops = chk_hops;
      sb.push_back(p);
   endtask

   always @(negedge clk) begin
      if (nrst) begin
         stall_prev = 1'b0;
      end else begin
         if (reward_done) done_cnt++;
         if (stall_prev) begin
            chk("stall_valid", tx.tx_valid, 1);
            chk("stall_type", tx.rPacketType, s_type);
            chk("stall_dest", tx.rDestinationID, s_dest);
            chk("stall_slot", tx.rTimeslot, s_slot);
            chk("stall_chosen", tx.rChosenCH, s_chosen);
         end
         stall_prev = tx.tx_valid && !tx.tx_ready;
         s_type = tx.rPacketType; s_dest = tx.rDestinationID;
         s_slot = tx.rTimeslot;   s_chosen = tx.rChosenCH;
         if (tx.tx_valid && tx.tx_ready) begin
            vectors++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_pkt observed type=%0h dest=%0h expected no packet",
                      tx.rPacketType, tx.rDestinationID);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("pkt_type", tx.rPacketType, e.t);
               chk("pkt_dest", tx.rDestinationID, e.dest);
               chk("pkt_chosen", tx.rChosenCH, e.chosen);
               chk("pkt_slot", tx.rTimeslot, e.slot);
               chk("pkt_src", tx.rSourceID, myNodeID);
               if (e.chk_hops) chk("pkt_hops", tx.rHopsFromCH, e.hops);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_en(input logic [2:0] t);
      en = 1'b1; fPacketType = t;
      step(1);
      en = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 60) begin step(1); n++; end
      chk(tag, busy, 0);
   endtask

   initial begin
      int d0, c0, n;
      nrst = 1'b1; en = 1'b0; fPacketType = T_HB; iAmDestination = 1'b0; iHaveData = 1'b0;
      low_E = 1'b0; role = 1'b0; myNodeID = 16'h0021; myEnergy = 16'h0300; myQValue = 16'h0055;
      hopsFromSink = 16'd3; chosenCH = 16'h0040; hopsFromCH = 16'd2; chosenHop = 16'd5;
      neighborCount = '0;
      tx.tx_ready = 1'b1;
      for (int i = 0; i < 32; i++) tbl[i] = 16'h0100 + 16'(i);
      tbl[0] = 16'd7; tbl[1] = 16'd9; tbl[2] = 16'd12;
      step(2);
      chk("rst_valid", tx.tx_valid, 0);
      chk("rst_type", tx.rPacketType, 3'b111);
      chk("rst_dest", tx.rDestinationID, 16'hFFFF);
      nrst = 1'b0;
      step(1);

      // 1: reset while a Data packet is stalled
      tx.tx_ready = 1'b0; iHaveData = 1'b1;
      step(1);
      iHaveData = 1'b0;
      step(2);
      chk("t1_stalled_valid", tx.tx_valid, 1);
      nrst = 1'b1;
      step(1);
      nrst = 1'b0;
      chk("t1_valid", tx.tx_valid, 0);
      chk("t1_type", tx.rPacketType, 3'b111);
      chk("t1_dest", tx.rDestinationID, 16'hFFFF);
      chk("t1_busy", busy, 0);
      tx.tx_ready = 1'b1;
      step(1);

      // 2: HB ripple latency, hb_lock suppression, Data clears lock
      push(T_HB, 16'hFFFF, chosenCH, 0, 0, 0);
      d0 = done_cnt;
      pulse_en(T_HB);
      chk("t2_valid_n1", tx.tx_valid, 1);
      chk("t2_type_n1", tx.rPacketType, T_HB);
      step(1);
      chk("t2_done_n2", reward_done, 1);
      chk("t2_valid_n2", tx.tx_valid, 0);
      step(1);
      chk("t2_idle_n3", busy, 0);
      pulse_en(T_HB);
      wait_idle("t2_idle_hb2");
      chk("t2_done_cnt", done_cnt, d0 + 2);
      pulse_en(T_DATA);
      wait_idle("t2_idle_data");
      push(T_HB, 16'hFFFF, chosenCH, 0, 0, 0);
      pulse_en(T_HB);
      wait_idle("t2_idle_hb3");
      chk("t2_sb_empty", sb.size(), 0);

      // 3: INV ripple as member, MR timeout, second INV neither ripples nor re-arms
      hopsFromCH = 16'd3;
      push(T_INV, 16'hFFFF, chosenCH, 0, 16'd4, 1);
      pulse_en(T_INV);
      c0 = cyc;
      wait_idle("t3_idle_inv");
      hopsFromCH = 16'd4;
      pulse_en(T_INV);
      wait_idle("t3_idle_inv2");
      push(T_MR, chosenCH, chosenCH, 0, 0, 0);
      n = 0;
      while (!(tx.tx_valid && tx.rPacketType == T_MR) && n < 40) begin step(1); n++; end
      chk("t3_mr_seen", tx.tx_valid, 1);
      chk("t3_mr_window", ((cyc - c0) >= 15 && (cyc - c0) <= 17), 1);
      wait_idle("t3_idle_mr");
      chk("t3_sb_empty", sb.size(), 0);

      // 4: cluster head INV then CHT sweep over three members with a stalling sink
      role = 1'b1; neighborCount = 6'd3;
      push(T_INV, 16'hFFFF, chosenCH, 0, 16'd0, 1);
      pulse_en(T_CHE);
      wait_idle("t4_idle_inv");
      push(T_CHT, 16'd7,  myNodeID, 16'd1, 0, 0);
      push(T_CHT, 16'd9,  myNodeID, 16'd2, 0, 0);
      push(T_CHT, 16'd12, myNodeID, 16'd3, 0, 0);
      d0 = done_cnt;
      n = 0;
      while (!(done_cnt == d0 + 1 && !busy) && n < 100) begin
         tx.tx_ready = ((n % 5) >= 2);
         step(1);
         n++;
      end
      tx.tx_ready = 1'b1;
      step(3);
      chk("t4_sweep_done", done_cnt, d0 + 1);
      chk("t4_sb_empty", sb.size(), 0);

      // 5: forwarding Data/SOS addressed to this node
      role = 1'b0; iAmDestination = 1'b1; low_E = 1'b1; hopsFromSink = 16'd1;
      push(T_SOS, 16'd0, chosenCH, 0, 0, 0);
      pulse_en(T_DATA);
      wait_idle("t5_idle_sos");
      hopsFromSink = 16'd3; low_E = 1'b0; chosenHop = 16'd5;
      push(T_DATA, 16'd5, chosenCH, 0, 0, 0);
      pulse_en(T_DATA);
      wait_idle("t5_idle_data");
      push(T_SOS, 16'd5, chosenCH, 0, 0, 0);
      pulse_en(T_SOS);
      wait_idle("t5_idle_sos2");
      iAmDestination = 1'b0;
      chk("t5_sb_empty", sb.size(), 0);

      // 6: MR expiring under a stalled Data EMIT is served right after it
      hopsFromCH = 16'd4;
      pulse_en(T_INV);
      wait_idle("t6_idle_arm");
      tx.tx_ready = 1'b0; iHaveData = 1'b1;
      push(T_DATA, 16'd5, chosenCH, 0, 0, 0);
      step(1);
      iHaveData = 1'b0;
      step(20);
      chk("t6_data_stalled", tx.rPacketType, T_DATA);
      push(T_MR, chosenCH, chosenCH, 0, 0, 0);
      tx.tx_ready = 1'b1;
      step(1);
      chk("t6_data_done", reward_done, 1);
      step(1);
      chk("t6_idle_gap", busy, 0);
      step(1);
      chk("t6_mr_valid", tx.tx_valid, 1);
      chk("t6_mr_type", tx.rPacketType, T_MR);
      wait_idle("t6_idle_mr");

      // 6b: sweep with an empty neighbor table finishes without a packet
      role = 1'b1; neighborCount = 6'd0;
      push(T_INV, 16'hFFFF, chosenCH, 0, 16'd0, 1);
      pulse_en(T_CHE);
      wait_idle("t6_idle_inv");
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 40) begin step(1); n++; end
      step(2);
      chk("t6_empty_sweep_done", done_cnt, d0 + 1);
      chk("t6_no_valid", tx.tx_valid, 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/reward_sched.md
Name: reward_sched

Overview:
- Next-generation packet packer for the EER-RL node. Sits between packetFilter / MY_NODE_INFO / kCH / QTUFMB / neighborTable and the transmit block.
- Decides which packet type to emit: HB, INV, MR, CHT, Data or SOS.
- Runs the MR and CHT timeouts internally.
- As cluster head, walks the neighbor table and emits one CHT packet per member, each carrying an assigned timeslot.
- All emissions use a valid/ready handshake.

Parameters:
- WORD_WIDTH, 16, width of every ID/energy/Q/hop field.
- MAX_NEIGHBORS, 32, neighbor table depth. IDX_W = $clog2(MAX_NEIGHBORS).
- MAX_CH_HOPS, 4, INV is rippled only while hopsFromCH < MAX_CH_HOPS.
- MR_TIMEOUT, 15, cycles from first INV seen to MR emission.
- CHT_TIMEOUT, 15, cycles from own INV emission to start of CHT sweep.
- BCAST_ID, 16'hFFFF, broadcast destination.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset: synchronous, active-high (1 = reset).
- en  in  1  packetFilter strobe; qualifies fPacketType for one cycle.
- fPacketType  in  3  received type: 000 HB, 001 CHE, 010 INV, 011 MR, 100 CHT, 101 Data, 110 SOS.
- iAmDestination  in  1  received Data/SOS is addressed to this node.
- iHaveData  in  1  level; node has own data to send.
- low_E  in  1  node energy is low; forwarded data goes out as SOS.
- role  in  1  1 = cluster head.
- myNodeID, myEnergy, myQValue, hopsFromSink  in  WORD_WIDTH each  node info.
- chosenCH, hopsFromCH  in  WORD_WIDTH each  from kCH.
- chosenHop  in  WORD_WIDTH  next hop from QTUFMB.
- neighborCount  in  IDX_W+1  valid entries in the neighbor table.
- mNodeID  in  WORD_WIDTH  neighbor table read data; valid one cycle after nTableIndex.
- nTableIndex  out  IDX_W  neighbor table read address.
- tx_valid  out  1  packet fields valid.
- tx_ready  in  1  transmit block accepts the packet.
- rPacketType  out  3  packet type.
- rSourceID, rEnergyLeft, rQValue, rSourceHops  out  WORD_WIDTH each  carry myNodeID, myEnergy, myQValue, hopsFromSink.
- rDestinationID, rChosenCH, rHopsFromCH, rTimeslot  out  WORD_WIDTH each  packet fields.
- busy  out  1  FSM not in IDLE.
- reward_done  out  1  one-cycle pulse at end of each job.

Behaviour:
- Reset (nrst=1 at an edge; overrides everything, including mid-sweep or mid-handshake):
  - tx_valid=0, busy=0, reward_done=0, rPacketType=3'b111.
  - rDestinationID=BCAST_ID; all other r* outputs, nTableIndex, timers, pend_mr, pend_cht and hb_lock = 0.
- States: IDLE, EMIT, CHT_RD, CHT_EMIT, DONE.
- IDLE job selection, evaluated each cycle in strict priority:
  1. pend_cht & role → CHT sweep.
  2. pend_mr & !role → MR.
  3. en-qualified event.
  4. iHaveData → Data.
- en-qualified events:
  - HB & !hb_lock → ripple HB; set hb_lock.
  - CHE & role → own INV, rHopsFromCH=0; arm CHT timer when the INV handshake completes.
  - INV & !role & hopsFromCH<MAX_CH_HOPS → ripple INV with rHopsFromCH=hopsFromCH+1 (WORD_WIDTH, no overflow possible). Independently of that hop check, INV & !role arms the MR timer if it is not already armed.
  - (Data|SOS) & iAmDestination → forward as 110 if (received SOS | low_E), else 101.
  - Data received (any destination) clears hb_lock.
  - Any other event → no packet; go straight to DONE.
- Destination field:
  - HB/INV → BCAST_ID.
  - MR → chosenCH.
  - CHT → mNodeID.
  - Data/SOS → 0 if hopsFromSink==1, else chosenHop.
- Other fields: rChosenCH=chosenCH for all non-CHT packets, myNodeID for CHT. rTimeslot=0 except in CHT.
- EMIT:
  - Fields and tx_valid are registered on the IDLE→EMIT edge.
  - tx_valid stays 1 and all fields are held stable until an edge with tx_ready=1, then go to DONE.
  - Latency: en at edge N → tx_valid=1 from N+1. If tx_ready=1 at N+1, reward_done=1 during N+2 and the FSM is back in IDLE at N+3.
- CHT sweep:
  - neighborCount==0 → DONE, no packet.
  - Otherwise i=0, CHT_RD drives nTableIndex=i; next edge latches mNodeID; CHT_EMIT presents type 100 with rTimeslot=i+1.
  - On handshake: if i==neighborCount-1 → DONE, else i++ and return to CHT_RD.
  - pend_cht clears at sweep start.
- Timers:
  - Down-counters. MR timer loads MR_TIMEOUT; CHT timer loads CHT_TIMEOUT.
  - They decrement every cycle regardless of FSM state. Reaching 0 sets the sticky pend_mr/pend_cht and disarms the timer.
  - pend_mr clears when the MR job starts.
  - If role changes, any pending flag for the other role is dropped.
- Busy rules:
  - en arriving while busy is ignored, except its hb_lock clear.
  - Pending flags persist and are served in the following IDLE cycle.
  - DONE always lasts exactly one cycle.
- tx_valid never drops without a handshake, except on reset.

Test Plan:
1. Reset mid-EMIT (tx_ready=0, nrst=1 one edge) → next cycle tx_valid=0, rPacketType=111, rDestinationID=FFFF, busy=0.
2. en, HB, hb_lock=0, tx_ready=1 → type 000 to FFFF at N+1, reward_done at N+2. A second HB → no packet, reward_done only. A Data en, then HB → HB emitted again.
3. !role, INV with hopsFromCH=3 → INV ripple with rHopsFromCH=4. After 15 cycles, MR with rDestinationID=chosenCH. A second INV with hopsFromCH=4 → no ripple and no re-arm.
4. role=1, CHE → INV, hops 0. Then neighborCount=3 with IDs 7,9,12 and tx_ready toggling 1/0 → three CHT packets to 7,9,12 with timeslots 1,2,3 and fields stable while stalled. Then one reward_done.
5. Data, iAmDestination=1, low_E=1, hopsFromSink=1 → type 110, dest 0. With hopsFromSink=3, low_E=0, chosenHop=5 → type 101, dest 5.
6. MR timer expires during a stalled Data EMIT → MR emitted immediately after the DONE/IDLE of the Data job. neighborCount=0 on a CHT sweep → reward_done with no tx_valid.
